// File: rtl/izhikevich_neuron.sv
// Izhikevich spiking neuron in IEEE-754 single precision; one Euler step per clock.
// Define NEURON_STATE_OUT_EN to expose the V/U state registers as V_OUT/U_OUT.
module izhikevich_neuron #(
    parameter logic [31:0] V_INIT   = 32'hC2820000,
    parameter logic [31:0] U_INIT   = 32'hC1500000,
    parameter logic [31:0] V_THRESH = 32'h41F00000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] I,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
`ifdef NEURON_STATE_OUT_EN
    output logic [31:0] V_OUT,
    output logic [31:0] U_OUT,
`endif
    output logic        SPIKED
);

    localparam logic [31:0] K004 = 32'h3D23D70A;
    localparam logic [31:0] K5   = 32'h40A00000;
    localparam logic [31:0] K140 = 32'h430C0000;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic [31:0] V;
    logic [31:0] U;
    logic [31:0] v_next;
    logic [31:0] u_next;
    logic [31:0] u_spk;
    logic        spike_now;

    function automatic logic is_nan(input logic [31:0] x);
        return (&x[30:23]) && (|x[22:0]);
    endfunction

    // Subnormals are treated as zero on input and flushed on output.
    function automatic logic [31:0] fmul(input logic [31:0] x,
                                         input logic [31:0] y);
        logic        s;
        logic        xz, yz, xi, yi;
        logic [47:0] p;
        logic [23:0] m;
        logic        g, st;
        logic [24:0] mr;
        int          e;
        s  = x[31] ^ y[31];
        xz = (x[30:23] == 8'd0);
        yz = (y[30:23] == 8'd0);
        xi = (x[30:23] == 8'hFF);
        yi = (y[30:23] == 8'hFF);
        if (is_nan(x) || is_nan(y)) return QNAN;
        if (xi || yi) return (xz || yz) ? QNAN : {s, 8'hFF, 23'd0};
        if (xz || yz) return {s, 31'd0};
        p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
        e = int'(x[30:23]) + int'(y[30:23]) - 127;
        if (p[47]) begin
            m  = p[47:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 1;
        end else begin
            m  = p[46:23];
            g  = p[22];
            st = |p[21:0];
        end
        mr = {1'b0, m} + {24'd0, g & (st | m[0])};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], mr[22:0]};
    endfunction

    // Mantissas carry guard/round/sticky below the 24 significant bits.
    function automatic logic [31:0] fadd(input logic [31:0] x,
                                         input logic [31:0] y);
        logic [31:0] hi, lo;
        logic        s;
        int          e, sh;
        logic [49:0] al;
        logic [26:0] mh, ml;
        logic [27:0] r;
        logic [24:0] mr;
        if (is_nan(x) || is_nan(y)) return QNAN;
        if ((&x[30:23]) && (&y[30:23]))
            return (x[31] == y[31]) ? x : QNAN;
        if (&x[30:23]) return x;
        if (&y[30:23]) return y;
        if (x[30:23] == 8'd0 && y[30:23] == 8'd0)
            return {x[31] & y[31], 31'd0};
        if (x[30:23] == 8'd0) return y;
        if (y[30:23] == 8'd0) return x;
        if (x[30:0] >= y[30:0]) begin
            hi = x;
            lo = y;
        end else begin
            hi = y;
            lo = x;
        end
        s  = hi[31];
        e  = int'(hi[30:23]);
        sh = e - int'(lo[30:23]);
        mh = {1'b1, hi[22:0], 3'b000};
        al = {1'b1, lo[22:0], 26'd0} >> sh;
        ml = {al[49:24], |al[23:0]};
        if (hi[31] == lo[31]) begin
            r = {1'b0, mh} + {1'b0, ml};
            if (r[27]) begin
                r = {1'b0, r[27:2], r[1] | r[0]};
                e = e + 1;
            end
        end else begin
            r = {1'b0, mh} - {1'b0, ml};
            if (r == 28'd0) return 32'd0;
            // Deep cancellation only occurs with near-equal exponents, so no
            // sticky information is lost by shifting left.
            for (int k = 0; k < 26; k++) begin
                if (!r[26]) begin
                    r = r << 1;
                    e = e - 1;
                end
            end
        end
        mr = {1'b0, r[26:3]} + {24'd0, r[2] & (r[1] | r[0] | r[3])};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], mr[22:0]};
    endfunction

    // Euler step of V and U plus the post-spike U update and threshold test.
    always_comb begin
        logic [31:0] vq, lin, p1, p2, p3, dv;
        logic [31:0] bv, du, adu;
        vq     = fmul(fmul(K004, V), V);
        lin    = fmul(K5, V);
        p1     = fadd(vq, lin);
        p2     = fadd(p1, K140);
        p3     = fadd(p2, {~U[31], U[30:0]});
        dv     = fadd(p3, I);
        v_next = fadd(V, dv);
        bv     = fmul(b, V);
        du     = fadd(bv, {~U[31], U[30:0]});
        adu    = fmul(a, du);
        u_next = fadd(U, adu);
        u_spk  = fadd(U, d);
        spike_now = !is_nan(V) && !V[31] && (V[30:0] >= V_THRESH[30:0]);
    end

    // State update: spike reset takes priority over the integration step.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            V      <= V_INIT;
            U      <= U_INIT;
            SPIKED <= 1'b0;
        end else if (spike_now) begin
            V      <= c;
            U      <= u_spk;
            SPIKED <= 1'b1;
        end else begin
            V      <= v_next;
            U      <= u_next;
            SPIKED <= 1'b0;
        end
    end

`ifdef NEURON_STATE_OUT_EN
    assign V_OUT = V;
    assign U_OUT = U;
`endif

endmodule

// File: tb/tb_izhikevich_neuron.sv
// Directed-vector bench for izhikevich_neuron.
// Expected values are hand-derived float32 bit patterns.
module tb_izhikevich_neuron;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] I, a, b, c, d;
    logic        SPIKED;
`ifdef NEURON_STATE_OUT_EN
    logic [31:0] V_OUT, U_OUT;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    izhikevich_neuron dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .I      (I),
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
`ifdef NEURON_STATE_OUT_EN
        .V_OUT  (V_OUT),
        .U_OUT  (U_OUT),
`endif
        .SPIKED (SPIKED)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp, input int tol = 0);
        int  dd;
        bit  ok;
        n_chk++;
        dd = int'(got[30:0]) - int'(exp[30:0]);
        if (dd < 0) dd = -dd;
        ok = (got === exp) ||
             (tol > 0 && !$isunknown(got) && got[31] == exp[31] && dd <= tol);
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
`ifdef NEURON_STATE_OUT_EN
        check("v_out", V_OUT, dut.V);
        check("u_out", U_OUT, dut.U);
`endif
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        #2;
        RESET = 1'b1;
    endtask

    task automatic run_burst(output int pulses, output int maxrun);
        int run;
        pulses = 0;
        maxrun = 0;
        run    = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (SPIKED) begin
                if (run == 0) pulses++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
    endtask

    int rs_n, rs_w, ch_n, ch_w;

    initial begin
        RESET = 1'b1;
        I = 32'h41200000;
        a = 32'h3CA3D70A;
        b = 32'h3E4CCCCD;
        c = 32'hC2820000;
        d = 32'h41000000;

        // asynchronous reset mid-clock
        #12;
        RESET = 1'b0;
        #1;
        check("rst_v", dut.V, 32'hC2820000);
        check("rst_u", dut.U, 32'hC1500000);
        check("rst_spk", {31'd0, SPIKED}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("rel_hold", dut.V, 32'hC2820000);

        // single RS step, I = 10
        step();
        check("rs1_v", dut.V, 32'hC2680000, 2);
        check("rs1_u", dut.U, 32'hC1500000, 2);
        check("rs1_spk", {31'd0, SPIKED}, 32'd0);

        // forced spike, I = 100
        do_reset();
        I = 32'h42C80000;
        step();
        check("fs1_v", dut.V, 32'h42000000, 2);
        check("fs1_spk", {31'd0, SPIKED}, 32'd0);
        step();
        check("fs2_spk", {31'd0, SPIKED}, 32'd1);
        check("fs2_v", dut.V, 32'hC2820000);
        check("fs2_u", dut.U, 32'hC0A00000, 2);
        step();
        check("fs3_spk", {31'd0, SPIKED}, 32'd0);
        check("fs3_v", dut.V, 32'h41C00000, 2);

        // reset while SPIKED is high, then replay
        do_reset();
        step();
        step();
        check("mr_pre_spk", {31'd0, SPIKED}, 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        check("mr_spk", {31'd0, SPIKED}, 32'd0);
        check("mr_v", dut.V, 32'hC2820000);
        check("mr_u", dut.U, 32'hC1500000);
        #1;
        RESET = 1'b1;
        step();
        check("mr1_v", dut.V, 32'h42000000, 2);
        check("mr1_spk", {31'd0, SPIKED}, 32'd0);
        step();
        check("mr2_spk", {31'd0, SPIKED}, 32'd1);
        check("mr2_v", dut.V, 32'hC2820000);
        check("mr2_u", dut.U, 32'hC0A00000, 2);

        // regular spiking vs chattering, I = 10
        I = 32'h41200000;
        c = 32'hC2820000;
        d = 32'h41000000;
        do_reset();
        run_burst(rs_n, rs_w);
        c = 32'hC2480000;
        d = 32'h40000000;
        do_reset();
        run_burst(ch_n, ch_w);
        check("rs_fires", {31'd0, rs_n > 0}, 32'd1);
        check("ch_gt_rs", {31'd0, ch_n > rs_n}, 32'd1);
        check("rs_width", rs_w, 32'd1);
        check("ch_width", ch_w, 32'd1);

        // c at threshold: back-to-back spikes
        I = 32'h42C80000;
        c = 32'h41F00000;
        d = 32'h41000000;
        do_reset();
        step();
        check("b2b0_spk", {31'd0, SPIKED}, 32'd0);
        step();
        check("b2b1_spk", {31'd0, SPIKED}, 32'd1);
        check("b2b1_v", dut.V, 32'h41F00000);
        step();
        check("b2b2_spk", {31'd0, SPIKED}, 32'd1);
        step();
        check("b2b3_spk", {31'd0, SPIKED}, 32'd1);

        // NaN input current
        c = 32'hC2820000;
        I = 32'h7FC00000;
        do_reset();
        step();
        check("nan1_v", dut.V, 32'h7FC00000);
        check("nan1_spk", {31'd0, SPIKED}, 32'd0);
        step();
        check("nan2_spk", {31'd0, SPIKED}, 32'd0);
        check("nan2_u", dut.U, 32'h7FC00000);
        step();
        check("nan3_spk", {31'd0, SPIKED}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/izhikevich_neuron.md
Name: izhikevich_neuron

Overview:
- Single Izhikevich spiking neuron with all state and parameters in IEEE-754 single precision.
- Performs one forward-Euler step (dt = 1 ms) of membrane potential V and recovery variable U every clock.
- Asserts a one-cycle spike flag when V reaches threshold.
- Leaf compute element inside the neuromorphic NoC core; parameters a, b, c, d and input current I are driven by the core's neuron-configuration logic.

Parameters:
- V_INIT, 32'hC2820000, V value loaded on reset (-65.0).
- U_INIT, 32'hC1500000, U value loaded on reset (-13.0).
- V_THRESH, 32'h41F00000, spike threshold (+30.0).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- I  input  32  input current, float32.
- a  input  32  recovery time-scale, float32.
- b  input  32  recovery sensitivity, float32.
- c  input  32  post-spike V reset value, float32.
- d  input  32  post-spike U increment, float32.
- SPIKED  output  1  registered spike flag.

Behaviour:
- State registers are named V and U (32-bit float each); benches probe them hierarchically.
- Reset: while RESET = 0, immediately and independent of CLK: V = V_INIT, U = U_INIT, SPIKED = 0.
- Reset may be asserted at any time, including mid-burst; release takes effect at the next rising edge.
- Each rising edge with RESET = 1, in priority order:
  - If V >= V_THRESH (float compare; +Inf counts as spiking): V <= c, U <= U + d, SPIKED <= 1.
  - Otherwise, using V/U values from before the edge: V <= V + (0.04·V·V + 5·V + 140 − U + I), U <= U + a·(b·V − U), SPIKED <= 0.
- Constants are float literals: 0.04 = 3D23D70A, 5.0 = 40A00000, 140.0 = 430C0000.
- Timing:
  - SPIKED is high for exactly the one cycle following the edge at which V was loaded with c.
  - A spike is therefore reported one clock after V first holds a value >= threshold.
  - Back-to-back spikes are possible if c >= V_THRESH.
- Arithmetic:
  - Float add/sub and multiply are combinational, with round-to-nearest-even.
  - Subnormal inputs and results flush to zero (sign preserved).
  - Overflow produces ±Inf. Inputs that are NaN propagate as quiet NaN (7FC00000).
  - A NaN V never spikes.
  - +0 and −0 compare equal.
- All inputs are sampled every cycle; changing I, a, b, c or d takes effect at the next edge with no latency.
- Single-cycle combinational datapath; no handshake, no stall, no internal FSM beyond the V/U/SPIKED registers.

Optional Feature:
- Macro NEURON_STATE_OUT_EN.
- When defined: two extra outputs, V_OUT [31:0] and U_OUT [31:0], continuously equal to V and U. They carry reset values during reset.
- When undefined: ports absent; state is visible only through hierarchical V/U.
- Core behaviour is identical in both cases.

Test Plan:
1. Reset: drive RESET = 0 mid-clock -> V = C2820000, U = C1500000, SPIKED = 0 immediately, without waiting for a clock edge.
2. Single RS step: a = 3CA3D70A, b = 3E4CCCCD, c = C2820000, d = 41000000, I = 41200000; release reset, one edge -> V = C2680000 (-58.0, ±2 ulp), U = C1500000 ±2 ulp, SPIKED = 0.
3. Forced spike: same parameters, I = 42C80000 (100.0).
   - Edge 1 -> V ≈ 42000000 (32.0), SPIKED = 0.
   - Edge 2 -> SPIKED = 1, V = C2820000, U ≈ C0A00000 (-5.0).
   - Edge 3 -> SPIKED = 0.
4. Chattering versus regular spiking, I = 10.0, 100 cycles each:
   - c = C2480000, d = 40000000 -> more SPIKED pulses than the RS run (c = C2820000, d = 41000000).
   - Every pulse lasts exactly 1 cycle.
5. Reset mid-operation: assert RESET = 0 on the cycle SPIKED = 1 -> SPIKED drops at once and V/U return to the init values. After release the trajectory repeats the scenario-3 sequence exactly.
6. Boundary and special values:
   - Set c = 41F00000 (30.0) -> SPIKED stays high on consecutive cycles.
   - Drive I = 7FC00000 (NaN) -> V becomes NaN and SPIKED stays 0.
   - With NEURON_STATE_OUT_EN defined, V_OUT/U_OUT match V/U every cycle.
